pipe_stall_ctrl: RTL and testbench

- Central pipeline controller for the 6-stage RISC-V core (PC, IF, ID, EX, MEM, WB).
- Merges stall requests from ID (load-use), EX (multi-cycle ALU) and MEM (data-memory handshake) into the stall[5:0] vector consumed by every inter-stage register, including MEM/WB.
- Owns the data-memory wait FSM with timeout.
- Defers branch flushes that collide with a MEM stall.
- Provides a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl_if.sv | 20 ++
 rtl/pipe_stall_ctrl.sv | 46 ++++
 tb/tb_pipe_stall_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: stall/flush control bus between the pipeline stages and the stall controller
interface pipe_stall_ctrl_if #(parameter int CNT_W = 32);
   logic             stallreq_id_i;
   logic             stallreq_ex_i;
   logic             mem_req_i;
   logic             dmem_ready_i;
   logic             branch_flush_i;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic             mem_err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   modport master (
      output stallreq_id_i, stallreq_ex_i, mem_req_i, dmem_ready_i, branch_flush_i,
      input  stall_o, flush_o, mem_err_o, stall_cnt_o
   );
   modport slave (
      input  stallreq_id_i, stallreq_ex_i, mem_req_i, dmem_ready_i, branch_flush_i,
      output stall_o, flush_o, mem_err_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/EX/MEM stall requests, runs the data-memory wait FSM with timeout,
// defers branch flushes across MEM stalls and counts stalled cycles.
module pipe_stall_ctrl #(
   parameter int TIMEOUT_W = 4,
   parameter int TIMEOUT   = 12,
   parameter int CNT_W     = 32
) (
   input logic             clk,
   input logic             rst,
   pipe_stall_ctrl_if.slave bus
);
   typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ERR} state_t;
   state_t               state;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 flush_pend;
   logic                 mem_stall;
   logic                 timeout;
   logic [5:0]           stall;
   always_comb begin
      mem_stall = (state == MEM_IDLE && bus.mem_req_i && !bus.dmem_ready_i) || state == MEM_WAIT;
      stall     = !rst                              ? 6'b000000 :
                  (mem_stall || state == MEM_ERR)   ? 6'b011111 :
                  bus.stallreq_ex_i                 ? 6'b001111 :
                  bus.stallreq_id_i                 ? 6'b000111 : 6'b000000;
      timeout   = wait_cnt >= TIMEOUT_W'(TIMEOUT - 1);
   end
   assign bus.stall_o   = stall;
   assign bus.flush_o   = rst && (bus.branch_flush_i || flush_pend) && !stall[4];
   assign bus.mem_err_o = state == MEM_ERR;
   // The detecting IDLE cycle counts as the first wait cycle, so entry loads 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= MEM_IDLE;
         wait_cnt        <= '0;
         flush_pend      <= 1'b0;
         bus.stall_cnt_o <= '0;
      end else begin
         state           <= state == MEM_IDLE ? (mem_stall ? MEM_WAIT : MEM_IDLE) :
                            state == MEM_WAIT ? (bus.dmem_ready_i ? MEM_IDLE : timeout ? MEM_ERR : MEM_WAIT) :
                            MEM_IDLE;
         wait_cnt        <= state == MEM_WAIT ? wait_cnt + 1'b1 : TIMEOUT_W'(1);
         flush_pend      <= stall[4] && (flush_pend || bus.branch_flush_i);
         bus.stall_cnt_o <= (stall != 6'b0 && !(&bus.stall_cnt_o)) ? bus.stall_cnt_o + 1'b1 : bus.stall_cnt_o;
      end
   end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed table-driven checks of the stall controller plus timeout,
// async-reset and counter-saturation sequences.
module tb_pipe_stall_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   pass = 0;
   int   total = 0;
   always #5 clk = ~clk;
   pipe_stall_ctrl_if #(.CNT_W(32)) bus ();
   pipe_stall_ctrl_if #(.CNT_W(2))  sbus ();
   assign sbus.stallreq_id_i  = bus.stallreq_id_i;
   assign sbus.stallreq_ex_i  = bus.stallreq_ex_i;
   assign sbus.mem_req_i      = bus.mem_req_i;
   assign sbus.dmem_ready_i   = bus.dmem_ready_i;
   assign sbus.branch_flush_i = bus.branch_flush_i;
   pipe_stall_ctrl #(.TIMEOUT_W(4), .TIMEOUT(12), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   pipe_stall_ctrl #(.TIMEOUT_W(4), .TIMEOUT(12), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(sbus.slave));
   typedef struct packed {
      logic        id, ex, req, rdy, br;
      logic [5:0]  st;
      logic        fl, er;
      logic [31:0] cnt;
   } vec_t;
   vec_t v[22];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask
   task automatic drive(input logic id, ex, req, rdy, br);
      bus.stallreq_id_i  = id;
      bus.stallreq_ex_i  = ex;
      bus.mem_req_i      = req;
      bus.dmem_ready_i   = rdy;
      bus.branch_flush_i = br;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      v[0]  = '{1,0,0,0,0, 6'b000111, 0,0, 0};
      v[1]  = '{1,0,0,0,0, 6'b000111, 0,0, 1};
      v[2]  = '{0,0,0,0,0, 6'b000000, 0,0, 2};
      v[3]  = '{0,1,0,0,0, 6'b001111, 0,0, 2};
      v[4]  = '{1,1,0,0,0, 6'b001111, 0,0, 3};
      v[5]  = '{0,0,0,0,1, 6'b000000, 1,0, 4};
      v[6]  = '{0,0,1,0,0, 6'b011111, 0,0, 4};
      v[7]  = '{0,0,1,0,0, 6'b011111, 0,0, 5};
      v[8]  = '{0,0,0,0,0, 6'b011111, 0,0, 6};
      v[9]  = '{0,0,1,1,0, 6'b011111, 0,0, 7};
      v[10] = '{0,0,0,0,0, 6'b000000, 0,0, 8};
      v[11] = '{1,1,1,0,0, 6'b011111, 0,0, 8};
      v[12] = '{1,1,1,1,0, 6'b011111, 0,0, 9};
      v[13] = '{1,1,0,0,0, 6'b001111, 0,0, 10};
      v[14] = '{0,0,0,0,0, 6'b000000, 0,0, 11};
      v[15] = '{0,0,1,0,1, 6'b011111, 0,0, 11};
      v[16] = '{0,0,1,0,0, 6'b011111, 0,0, 12};
      v[17] = '{0,0,1,1,1, 6'b011111, 0,0, 13};
      v[18] = '{0,0,0,0,0, 6'b000000, 1,0, 14};
      v[19] = '{0,0,0,0,0, 6'b000000, 0,0, 14};
      v[20] = '{1,0,0,0,1, 6'b000111, 1,0, 14};
      v[21] = '{0,0,0,0,0, 6'b000000, 0,0, 15};
      // Outputs stay low in reset even with a MEM miss and a branch presented.
      drive(0, 0, 1, 0, 1);
      #2;
      chk("rst_stall", 32'(bus.stall_o), 32'h0);
      chk("rst_flush", 32'(bus.flush_o), 32'h0);
      chk("rst_err", 32'(bus.mem_err_o), 32'h0);
      chk("rst_cnt", bus.stall_cnt_o, 32'h0);
      drive(0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 22; i++) begin
         drive(v[i].id, v[i].ex, v[i].req, v[i].rdy, v[i].br);
         @(negedge clk);
         chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(v[i].st));
         chk($sformatf("vec%0d_flush", i), 32'(bus.flush_o), 32'(v[i].fl));
         chk($sformatf("vec%0d_err", i), 32'(bus.mem_err_o), 32'(v[i].er));
         chk($sformatf("vec%0d_cnt", i), bus.stall_cnt_o, v[i].cnt);
         tick();
      end
      // Timeout: 1 detect + 11 waits + 1 abort cycle; a branch in the abort cycle is deferred.
      for (int i = 0; i < 13; i++) begin
         drive(0, 0, 1, 0, i == 12);
         @(negedge clk);
         chk($sformatf("to%0d_stall", i), 32'(bus.stall_o), 32'h1f);
         chk($sformatf("to%0d_err", i), 32'(bus.mem_err_o), 32'(i == 12));
         chk($sformatf("to%0d_flush", i), 32'(bus.flush_o), 32'h0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("to_after_stall", 32'(bus.stall_o), 32'h0);
      chk("to_after_err", 32'(bus.mem_err_o), 32'h0);
      chk("to_after_flush", 32'(bus.flush_o), 32'h1);
      chk("to_after_cnt", bus.stall_cnt_o, 32'd28);
      tick();
      @(negedge clk);
      chk("to_flush_once", 32'(bus.flush_o), 32'h0);
      tick();
      // Async reset while in MEM_WAIT with a pending flush.
      drive(0, 0, 1, 0, 1);
      tick();
      drive(0, 0, 1, 0, 0);
      @(negedge clk);
      chk("pre_rst_stall", 32'(bus.stall_o), 32'h1f);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_stall", 32'(bus.stall_o), 32'h0);
      chk("arst_flush", 32'(bus.flush_o), 32'h0);
      chk("arst_cnt", bus.stall_cnt_o, 32'h0);
      chk("arst_err", 32'(bus.mem_err_o), 32'h0);
      drive(0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_flush", i), 32'(bus.flush_o), 32'h0);
         chk($sformatf("post_rst%0d_stall", i), 32'(bus.stall_o), 32'h0);
         tick();
      end
      // Saturation: the 2-bit counter holds at 3 while the wide one reaches 5.
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("cnt_main", bus.stall_cnt_o, 32'd5);
      chk("cnt_sat", 32'(sbus.stall_cnt_o), 32'd3);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
